// File: rtl/coeff_token_vlc_packer_if.sv
// coeff_token_vlc_packer_if: token input and packed-word output bundle for the coeff_token packer
interface coeff_token_vlc_packer_if #(
  parameter int OUT_W = 32,
  parameter int CNT_W = 7
);
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [4:0]       in_total_coeff;
  logic [1:0]       in_trail_ones;
  logic             in_flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_nbits;
  logic             out_last;
  logic             err;
  modport master (
    output in_valid, in_mode, in_total_coeff, in_trail_ones, in_flush, out_ready,
    input  in_ready, out_valid, out_data, out_nbits, out_last, err
  );
  modport slave (
    input  in_valid, in_mode, in_total_coeff, in_trail_ones, in_flush, out_ready,
    output in_ready, out_valid, out_data, out_nbits, out_last, err
  );
endinterface

// File: rtl/coeff_token_vlc_packer.sv
// coeff_token_vlc_packer: CAVLC coeff_token lookup (chroma DC / FLC) and MSB-first word packer; define CT_ILLEGAL_CHK_EN for the err pulse
module coeff_token_vlc_packer #(
  parameter int OUT_W = 32,
  parameter int CNT_W = 7
) (
  input logic clk,
  input logic rst,
  coeff_token_vlc_packer_if.slave bus
);
  localparam int AW = OUT_W + 8;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(OUT_W);
  typedef enum logic {S_RUN, S_DRAIN} state_t;
  state_t           state;
  logic             l_valid, l_flush;
  logic [7:0]       l_code, lk_code;
  logic [3:0]       l_len, lk_len;
  logic [AW-1:0]    acc;
  logic [CNT_W-1:0] fill;
  logic             illegal, accept, append, emit, last_word, out_valid;
  assign accept    = bus.in_valid & bus.in_ready;
  assign append    = l_valid & (fill < FULL) & (state == S_RUN);
  assign last_word = (state == S_DRAIN) & (fill <= FULL);
  assign out_valid = (state == S_DRAIN) | (fill >= FULL);
  assign emit      = out_valid & bus.out_ready;
  assign bus.in_ready  = !rst & (state == S_RUN) & (!l_valid | append);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = acc[AW-1 -: OUT_W];
  assign bus.out_nbits = !out_valid ? '0 : last_word ? fill : FULL;
  assign bus.out_last  = last_word;
  // Table lookup: {len, code} with the code right-aligned; illegal tokens contribute no bits
  always_comb begin
    illegal = ({3'b000, bus.in_trail_ones} > bus.in_total_coeff) |
              (bus.in_mode ? bus.in_total_coeff > 5'd16 : bus.in_total_coeff > 5'd4);
    {lk_len, lk_code} = 12'h000;
    if (bus.in_mode)
      {lk_len, lk_code} = bus.in_total_coeff == 5'd0 ? 12'h603 :
                          {4'd6, 2'b00, 4'(bus.in_total_coeff - 5'd1), bus.in_trail_ones};
    else
      case ({bus.in_trail_ones, bus.in_total_coeff[2:0]})
        5'b00_000: {lk_len, lk_code} = 12'h201;
        5'b00_001: {lk_len, lk_code} = 12'h607;
        5'b01_001: {lk_len, lk_code} = 12'h101;
        5'b00_010: {lk_len, lk_code} = 12'h604;
        5'b01_010: {lk_len, lk_code} = 12'h606;
        5'b10_010: {lk_len, lk_code} = 12'h301;
        5'b00_011: {lk_len, lk_code} = 12'h603;
        5'b01_011: {lk_len, lk_code} = 12'h703;
        5'b10_011: {lk_len, lk_code} = 12'h702;
        5'b11_011: {lk_len, lk_code} = 12'h605;
        5'b00_100: {lk_len, lk_code} = 12'h602;
        5'b01_100: {lk_len, lk_code} = 12'h803;
        5'b10_100: {lk_len, lk_code} = 12'h802;
        5'b11_100: {lk_len, lk_code} = 12'h700;
        default:   {lk_len, lk_code} = 12'h000;
      endcase
    lk_len = illegal ? 4'd0 : lk_len;
  end
  // Lookup register, append into the accumulator, word emission and drain control
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RUN;
      l_valid <= 1'b0;
      l_flush <= 1'b0;
      l_code  <= '0;
      l_len   <= '0;
      acc     <= '0;
      fill    <= '0;
    end else begin
      if (accept) begin
        l_valid <= 1'b1;
        l_code  <= lk_code;
        l_len   <= lk_len;
        l_flush <= bus.in_flush;
      end else if (append) l_valid <= 1'b0;
      if (append) begin
        acc  <= acc | (({l_code, {OUT_W{1'b0}}} << (4'd8 - l_len)) >> fill);
        fill <= fill + CNT_W'(l_len);
        if (l_flush) state <= S_DRAIN;
      end else if (emit) begin
        acc  <= acc << OUT_W;
        fill <= fill > FULL ? fill - FULL : '0;
        if (last_word) state <= S_RUN;
      end
    end
  end
`ifdef CT_ILLEGAL_CHK_EN
  logic err_q;
  // One-cycle pulse following acceptance of an illegal token
  always_ff @(posedge clk) err_q <= rst ? 1'b0 : accept & illegal;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_coeff_token_vlc_packer.sv
// tb_coeff_token_vlc_packer: scoreboard bench for the coeff_token packer at OUT_W=16
module tb_coeff_token_vlc_packer;
  localparam int OUT_W = 16;
  localparam int CNT_W = 7;
  typedef struct packed {logic [OUT_W-1:0] data; logic [CNT_W-1:0] nbits; logic last;} word_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int asserts = 0;
  int fails = 0;
  word_t exp_q[$];
  bit mq[$];
  coeff_token_vlc_packer_if #(.OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();
  coeff_token_vlc_packer #(.OUT_W(OUT_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic string ref_bits(input logic m, input int tc, input int t1);
    string s;
    logic [5:0] v;
    s = "";
    if (t1 > tc || tc > (m ? 16 : 4)) return s;
    if (m) begin
      if (tc == 0) return "000011";
      v = {4'(tc - 1), 2'(t1)};
      for (int i = 5; i >= 0; i--) s = {s, v[i] ? "1" : "0"};
      return s;
    end
    case (tc * 4 + t1)
      0: s = "01";
      4: s = "000111";
      5: s = "1";
      8: s = "000100";
      9: s = "000110";
      10: s = "001";
      12: s = "000011";
      13: s = "0000011";
      14: s = "0000010";
      15: s = "000101";
      16: s = "000010";
      17: s = "00000011";
      18: s = "00000010";
      19: s = "0000000";
      default: s = "";
    endcase
    return s;
  endfunction
  task automatic pop_word(input int n, input logic last);
    logic [OUT_W-1:0] d = '0;
    for (int i = 0; i < n; i++) d[OUT_W-1-i] = mq.pop_front();
    exp_q.push_back({d, CNT_W'(n), last});
  endtask
  task automatic model_push(input logic m, input int tc, input int t1, input logic fl);
    string s = ref_bits(m, tc, t1);
    for (int i = 0; i < s.len(); i++) mq.push_back(s[i] == "1");
    while (mq.size() > OUT_W || (!fl && mq.size() == OUT_W)) pop_word(OUT_W, 1'b0);
    if (fl) pop_word(mq.size(), 1'b1);
  endtask
  task automatic monitor;
    word_t got, want;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        got = {bus.out_data, bus.out_nbits, bus.out_last};
        asserts++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL word_unexpected got data=%h nbits=%0d last=%0b, required no word", got.data, got.nbits, got.last);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            fails++;
            $display("FAIL word got data=%h nbits=%0d last=%0b, required data=%h nbits=%0d last=%0b",
                     got.data, got.nbits, got.last, want.data, want.nbits, want.last);
          end
        end
      end
    end
  endtask
  task automatic send(input logic m, input int tc, input int t1, input logic fl);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_mode = m;
    bus.in_total_coeff = 5'(tc);
    bus.in_trail_ones = 2'(t1);
    bus.in_flush = fl;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      @(posedge clk);
      #1;
      if (n > 4) bus.out_ready = 1'b1;
      @(negedge clk);
      n++;
    end
    asserts++;
    if (bus.in_ready) model_push(m, tc, t1, fl);
    else begin
      fails++;
      $display("FAIL send_timeout in_ready=0, required 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_drain;
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    asserts++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout pending=%0d, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    asserts++;
    if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b, required 0", bus.in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    asserts++;
    if ({bus.out_valid, bus.out_last, bus.err} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags got valid=%b last=%b err=%b, required 0/0/0", bus.out_valid, bus.out_last, bus.err);
    end
    asserts++;
    if (bus.out_data !== '0 || bus.out_nbits !== '0) begin
      fails++;
      $display("FAIL reset_data got data=%h nbits=%0d, required 0/0", bus.out_data, bus.out_nbits);
    end
    asserts++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got %b, required 1", bus.in_ready); end
    @(posedge clk);
    #1;
  endtask
  task automatic test_chroma_ones;
    for (int i = 0; i < 16; i++) send(1'b0, 1, 1, 1'b0);
    wait_drain();
  endtask
  task automatic test_flc_flush;
    repeat (3) send(1'b1, 5, 2, 1'b0);
    send(1'b1, 0, 0, 1'b1);
    wait_drain();
  endtask
  task automatic test_chroma_flush;
    send(1'b0, 0, 0, 1'b1);
    send(1'b0, 5, 0, 1'b1);
    wait_drain();
  endtask
  task automatic test_backpressure;
    int n_acc = 0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_mode = 1'b0;
    bus.in_total_coeff = 5'd4;
    bus.in_trail_ones = 2'd1;
    bus.in_flush = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.in_ready) begin
        model_push(1'b0, 4, 1, 1'b0);
        n_acc++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      asserts++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0303) begin
        fails++;
        $display("FAIL stall_hold cycle %0d got valid=%b data=%h, required 1/0303", c, bus.out_valid, bus.out_data);
      end
    end
    asserts++;
    if (n_acc != 3 || bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL stall_accept got accepted=%0d in_ready=%b, required 3/0", n_acc, bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(1'b0, 0, 0, 1'b1);
    wait_drain();
  endtask
  task automatic test_illegal;
    logic e = 1'b0;
`ifdef CT_ILLEGAL_CHK_EN
    e = 1'b1;
`endif
    send(1'b0, 1, 1, 1'b0);
    send(1'b0, 5, 0, 1'b0);
    asserts++;
    if (bus.err !== e) begin fails++; $display("FAIL err_pulse got %b, required %b", bus.err, e); end
    @(posedge clk);
    #1;
    asserts++;
    if (bus.err !== 1'b0) begin fails++; $display("FAIL err_width got %b, required 0", bus.err); end
    send(1'b1, 1, 3, 1'b0);
    asserts++;
    if (bus.err !== e) begin fails++; $display("FAIL err_flc got %b, required %b", bus.err, e); end
    send(1'b0, 0, 0, 1'b1);
    wait_drain();
  endtask
  task automatic test_reset_mid_drain;
    logic seen = 1'b0;
    bus.out_ready = 1'b0;
    send(1'b1, 5, 2, 1'b0);
    send(1'b1, 0, 0, 1'b1);
    repeat (2) @(negedge clk);
    asserts++;
    if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b1 || bus.out_nbits !== CNT_W'(12)) begin
      fails++;
      $display("FAIL drain_pending got valid=%b last=%b nbits=%0d, required 1/1/12", bus.out_valid, bus.out_last, bus.out_nbits);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    mq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    asserts++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_drain_valid got %b, required 0", bus.out_valid); end
    repeat (10) begin
      @(negedge clk);
      seen = seen | bus.out_valid;
    end
    asserts++;
    if (seen !== 1'b0) begin fails++; $display("FAIL rst_drain_quiet got valid seen=%b, required 0", seen); end
    @(posedge clk);
    #1;
    send(1'b0, 1, 1, 1'b1);
    wait_drain();
  endtask
  task automatic test_back_to_back;
    int m, tc, t1;
    for (int i = 0; i < 60; i++) begin
      m = $urandom_range(0, 1);
      tc = m ? $urandom_range(0, 16) : $urandom_range(0, 4);
      t1 = $urandom_range(0, tc < 3 ? tc : 3);
      bus.out_ready = $urandom_range(0, 3) != 0;
      send(1'(m), tc, t1, i == 59 || $urandom_range(0, 9) == 0);
    end
    bus.out_ready = 1'b1;
    wait_drain();
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_mode = 1'b0;
    bus.in_total_coeff = '0;
    bus.in_trail_ones = '0;
    bus.in_flush = 1'b0;
    bus.out_ready = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_chroma_ones();
    test_flc_flush();
    test_chroma_flush();
    test_backpressure();
    test_illegal();
    test_reset_mid_drain();
    test_back_to_back();
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
